mel_filter_sched: RTL and testbench



---
 rtl/mel_sched_pkg.sv | 24 ++
 rtl/mel_weight_mac.sv | 43 ++++
 rtl/mel_filter_sched.sv | 187 ++++++++++++++++++
 tb/tb_mel_filter_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mel_sched_pkg.sv
// Shared definitions for the mel-filterbank scheduler.
// Holds the FSM state encoding, the ROM filter-id markers, the ROM word
// field positions and the accumulator width.
package mel_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      MAC,
      FLUSH
   } state_t;

   // filt_id markers: PRE feeds only the rising half of filter 0, SKIP ignores the bin
   localparam logic [7:0] FILT_PRE  = 8'hFF;
   localparam logic [7:0] FILT_SKIP = 8'hFE;

   localparam int unsigned FID_MSB = 23;
   localparam int unsigned FID_LSB = 16;
   localparam int unsigned W_MSB   = 15;

   localparam int unsigned ACC_W = 64;

endpackage

// File: rtl/mel_weight_mac.sv
// Triangular-weight arithmetic for one spectrum bin.
// Ports:
//   p         power sample
//   w         falling-edge weight, unsigned Q0.16
//   acc       accumulator to be scaled for output
//   prod_lo_c p*w, zero-extended to the accumulator width
//   prod_hi_c p*(65536-w), zero-extended to the accumulator width
//   scaled_c  acc>>16, saturated to all-ones at OUT_W bits
module mel_weight_mac
   import mel_sched_pkg::*;
#(
   parameter int unsigned PWR_W = 32,
   parameter int unsigned OUT_W = 40
) (
   input  logic [PWR_W-1:0] p,
   input  logic [15:0]      w,
   input  logic [ACC_W-1:0] acc,
   output logic [ACC_W-1:0] prod_lo_c,
   output logic [ACC_W-1:0] prod_hi_c,
   output logic [OUT_W-1:0] scaled_c
);

   localparam int unsigned LO_W = PWR_W + 16;
   localparam int unsigned HI_W = PWR_W + 17;
   localparam int unsigned SH_W = ACC_W - 16;

   logic [16:0]     w_inv;
   logic [LO_W-1:0] lo;
   logic [HI_W-1:0] hi;
   logic [SH_W-1:0] sh;

   // 65536-w needs 17 bits so that w=0 gives the full weight
   always_comb begin
      w_inv     = 17'h10000 - {1'b0, w};
      lo        = LO_W'(p) * LO_W'(w);
      hi        = HI_W'(p) * HI_W'(w_inv);
      prod_lo_c = ACC_W'(lo);
      prod_hi_c = ACC_W'(hi);
      sh        = acc[ACC_W-1:16];
      scaled_c  = (|sh[SH_W-1:OUT_W]) ? '1 : sh[OUT_W-1:0];
   end

endmodule

// File: rtl/mel_filter_sched.sv
// Mel-filterbank pass sequencer: walks spectrum RAM and melbank ROM bin by
// bin, accumulates triangular weights into two running accumulators and
// streams one energy per filter over valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start/busy/done/err frame control and sticky coefficient-sequence error
//   spec_addr/spec_rd_data  power-spectrum RAM read port
//   rom_addr/rom_rd_data    melbank ROM read port ({filt_id, w})
//   mel_valid/mel_ready/mel_idx/mel_data  output energy stream
module mel_filter_sched
   import mel_sched_pkg::*;
#(
   parameter int unsigned N_BINS = 257,
   parameter int unsigned N_FILT = 26,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned PWR_W  = 32,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned OUT_W  = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] spec_addr,
   input  logic [PWR_W-1:0]  spec_rd_data,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_rd_data,
   output logic              mel_valid,
   input  logic              mel_ready,
   output logic [7:0]        mel_idx,
   output logic [OUT_W-1:0]  mel_data
);

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  k;
   logic [7:0]         cur_f;
   logic [ACC_W-1:0]   acc_lo, acc_hi;
   logic [PWR_W-1:0]   p_reg;
   logic [23:0]        word_reg;
   logic [1:0]         wait_cnt;

   logic [ACC_W-1:0]   prod_lo_c, prod_hi_c;
   logic [OUT_W-1:0]   scaled_c;
   logic [7:0]         fid;
   logic signed [8:0]  fe, cur_s;
   logic               fid_bad, out_free, step_emit, can_step, last_bin;
   logic               start_acc, capture, do_acc, do_step, next_bin, set_err, finish;

   mel_weight_mac #(
      .PWR_W (PWR_W),
      .OUT_W (OUT_W)
   ) u_mac (
      .p         (p_reg),
      .w         (word_reg[W_MSB:0]),
      .acc       (acc_lo),
      .prod_lo_c (prod_lo_c),
      .prod_hi_c (prod_hi_c),
      .scaled_c  (scaled_c)
   );

   // Filter indices compared as signed so FILT_PRE behaves as filter -1
   always_comb begin
      fid       = word_reg[FID_MSB:FID_LSB];
      fe        = (fid == FILT_PRE) ? -9'sd1 : $signed({1'b0, fid});
      cur_s     = (cur_f == FILT_PRE) ? -9'sd1 : $signed({1'b0, cur_f});
      fid_bad   = (fid != FILT_PRE) && (fid != FILT_SKIP) && (fid >= 8'(N_FILT));
      out_free  = !mel_valid || mel_ready;
      step_emit = (cur_f != FILT_PRE);
      can_step  = !step_emit || out_free;
      last_bin  = (k == ADDR_W'(N_BINS - 1));
   end

   // Next-state and datapath strobes
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      capture   = 1'b0;
      do_acc    = 1'b0;
      do_step   = 1'b0;
      next_bin  = 1'b0;
      set_err   = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: state_nxt = WAIT;
         WAIT: begin
            if (wait_cnt == 2'(RD_LAT - 1)) begin
               capture   = 1'b1;
               state_nxt = MAC;
            end
         end
         MAC: begin
            if (fid == FILT_SKIP) begin
               next_bin = 1'b1;
            end else if (fid_bad || (fe < cur_s)) begin
               set_err  = 1'b1;
               next_bin = 1'b1;
            end else if (fe == cur_s) begin
               do_acc   = 1'b1;
               next_bin = 1'b1;
            end else if (can_step) begin
               do_step = 1'b1;
            end
            if (next_bin) state_nxt = last_bin ? FLUSH : FETCH;
         end
         FLUSH: begin
            if (cur_f != 8'(N_FILT)) begin
               do_step = can_step;
            end else if (out_free) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         cur_f     <= FILT_PRE;
         acc_lo    <= '0;
         acc_hi    <= '0;
         p_reg     <= '0;
         word_reg  <= '0;
         wait_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         spec_addr <= '0;
         rom_addr  <= '0;
         mel_valid <= 1'b0;
         mel_idx   <= '0;
         mel_data  <= '0;
      end else begin
         state    <= state_nxt;
         done     <= finish;
         wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
         if (mel_valid && mel_ready) mel_valid <= 1'b0;
         if (start_acc) begin
            busy      <= 1'b1;
            err       <= 1'b0;
            k         <= '0;
            cur_f     <= FILT_PRE;
            acc_lo    <= '0;
            acc_hi    <= '0;
            spec_addr <= '0;
            rom_addr  <= '0;
         end
         if (finish) busy <= 1'b0;
         if (capture) begin
            p_reg    <= spec_rd_data;
            word_reg <= rom_rd_data;
         end
         if (set_err) err <= 1'b1;
         if (do_acc) begin
            acc_lo <= acc_lo + prod_lo_c;
            acc_hi <= acc_hi + prod_hi_c;
         end
         // Step: retire filter cur_f, slide the window up by one filter
         if (do_step) begin
            if (step_emit) begin
               mel_valid <= 1'b1;
               mel_idx   <= cur_f;
               mel_data  <= scaled_c;
            end
            acc_lo <= acc_hi;
            acc_hi <= '0;
            cur_f  <= cur_f + 8'd1;
         end
         if (next_bin && !last_bin) begin
            k         <= k + ADDR_W'(1);
            spec_addr <= k + ADDR_W'(1);
            rom_addr  <= k + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mel_filter_sched.sv
// Directed bench for mel_filter_sched: table of frame vectors plus
// hand-written backpressure, reset, and start-while-busy sequences.
module tb_mel_filter_sched;

   localparam int unsigned NB = 8;
   localparam int unsigned NF = 5;
   localparam int unsigned NV = 4;

   logic        clk = 1'b0;
   logic        rst, start, mel_ready;
   logic        busy, done, err, mel_valid;
   logic [8:0]  spec_addr, rom_addr;
   logic [31:0] spec_rd_data;
   logic [23:0] rom_rd_data;
   logic [7:0]  mel_idx;
   logic [39:0] mel_data;

   always #5 clk = ~clk;

   mel_filter_sched #(
      .N_BINS (NB),
      .N_FILT (NF),
      .ADDR_W (9),
      .PWR_W  (32),
      .RD_LAT (1),
      .OUT_W  (40)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .spec_addr    (spec_addr),
      .spec_rd_data (spec_rd_data),
      .rom_addr     (rom_addr),
      .rom_rd_data  (rom_rd_data),
      .mel_valid    (mel_valid),
      .mel_ready    (mel_ready),
      .mel_idx      (mel_idx),
      .mel_data     (mel_data)
   );

   typedef struct packed {
      logic [NB-1:0][31:0] p;
      logic [NB-1:0][23:0] rom;
      logic [NF-1:0][39:0] expv;
      logic                exp_err;
   } vec_t;

   vec_t        vecs [NV];
   logic [31:0] spec_mem [NB];
   logic [23:0] rom_mem [NB];
   int          total = 0;
   int          bad = 0;
   int          done_cnt = 0;
   logic [7:0]  got_idx [$];
   logic [39:0] got_data [$];

   // single-cycle read latency memory models
   always @(posedge clk) begin
      spec_rd_data <= spec_mem[spec_addr[2:0]];
      rom_rd_data  <= rom_mem[rom_addr[2:0]];
   end

   // transfer and done logger, sampled mid-cycle
   always @(negedge clk) begin
      if (mel_valid && mel_ready) begin
         got_idx.push_back(mel_idx);
         got_data.push_back(mel_data);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic load(input int v);
      for (int b = 0; b < NB; b++) begin
         spec_mem[b] = vecs[v].p[b];
         rom_mem[b]  = vecs[v].rom[b];
      end
   endtask

   task automatic clear_log();
      got_idx.delete();
      got_data.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input int v, input string tag);
      int n;
      n = got_idx.size();
      check($sformatf("%s_count", tag), 64'(n), 64'(NF));
      for (int i = 0; i < NF && i < n; i++) begin
         check($sformatf("%s_idx%0d", tag, i), 64'(got_idx[i]), 64'(i));
         check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(vecs[v].expv[i]));
      end
      check($sformatf("%s_err", tag), 64'(err), 64'(vecs[v].exp_err));
      check($sformatf("%s_done", tag), 64'(done_cnt), 64'd1);
      check($sformatf("%s_busy", tag), 64'(busy), 64'd0);
   endtask

   initial begin
      logic [7:0]  h_idx;
      logic [39:0] h_data;
      int          unstable, busylow;

      for (int v = 0; v < NV; v++) begin
         for (int b = 0; b < NB; b++) begin
            vecs[v].p[b]   = 32'd0;
            vecs[v].rom[b] = 24'hFE0000;
         end
         vecs[v].expv    = '0;
         vecs[v].exp_err = 1'b0;
      end
      // 0: basic weighting
      vecs[0].p[0] = 32'd4;   vecs[0].rom[0] = 24'hFF8000;
      vecs[0].p[1] = 32'd8;   vecs[0].rom[1] = 24'h004000;
      vecs[0].p[2] = 32'd16;  vecs[0].rom[2] = 24'h01FFFF;
      vecs[0].p[3] = 32'd100; vecs[0].rom[3] = 24'hFE0000;
      vecs[0].expv[0] = 40'd4;
      vecs[0].expv[1] = 40'd21;
      // 1: gap 00 -> 03, filters 1 and 2 zero
      vecs[1].p[0] = 32'd3;  vecs[1].rom[0] = 24'hFF0000;
      vecs[1].p[1] = 32'd10; vecs[1].rom[1] = 24'h00FFFF;
      vecs[1].p[2] = 32'd4;  vecs[1].rom[2] = 24'h038000;
      vecs[1].expv[0] = 40'd12;
      vecs[1].expv[3] = 40'd2;
      vecs[1].expv[4] = 40'd2;
      // 2: sequence error 02 then 01
      vecs[2].p[0] = 32'd5; vecs[2].rom[0] = 24'h000000;
      vecs[2].p[1] = 32'd7; vecs[2].rom[1] = 24'h020000;
      vecs[2].p[2] = 32'd9; vecs[2].rom[2] = 24'h010000;
      vecs[2].expv[1] = 40'd5;
      vecs[2].expv[3] = 40'd7;
      vecs[2].exp_err = 1'b1;
      // 3: full-scale power, w=0 everywhere
      for (int b = 0; b < NB; b++) begin
         vecs[3].p[b]   = 32'hFFFF_FFFF;
         vecs[3].rom[b] = (b < 4) ? 24'hFF0000 : 24'h000000;
      end
      vecs[3].expv[0] = 40'h3_FFFF_FFFC;
      vecs[3].expv[1] = 40'h3_FFFF_FFFC;

      rst = 1'b1;
      start = 1'b0;
      mel_ready = 1'b1;
      load(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_valid", 64'(mel_valid), 64'd0);
      check("rst_idx", 64'(mel_idx), 64'd0);
      check("rst_data", 64'(mel_data), 64'd0);
      check("rst_addr", 64'({spec_addr, rom_addr}), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // table-driven frames; vector 3 follows the error frame, so err must clear
      for (int v = 0; v < NV; v++) begin
         load(v);
         clear_log();
         pulse_start();
         check($sformatf("v%0d_busy_run", v), 64'(busy), 64'd1);
         wait_done();
         check_frame(v, $sformatf("v%0d", v));
      end

      // backpressure on the first emission
      load(0);
      clear_log();
      mel_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 200 && !mel_valid; i++) @(negedge clk);
      check("bp_valid", 64'(mel_valid), 64'd1);
      h_idx = mel_idx;
      h_data = mel_data;
      unstable = 0;
      busylow = 0;
      repeat (20) begin
         @(negedge clk);
         if (!mel_valid || mel_idx !== h_idx || mel_data !== h_data) unstable++;
         if (!busy) busylow++;
      end
      check("bp_stable", 64'(unstable), 64'd0);
      check("bp_busy", 64'(busylow), 64'd0);
      check("bp_first_idx", 64'(h_idx), 64'd0);
      check("bp_first_data", 64'(h_data), 64'd4);
      @(posedge clk);
      #1 mel_ready = 1'b1;
      wait_done();
      check_frame(0, "bp");

      // start while busy is ignored
      load(1);
      clear_log();
      pulse_start();
      repeat (10) @(posedge clk);
      #1;
      pulse_start();
      wait_done();
      repeat (80) @(posedge clk);
      #1;
      check_frame(1, "sb");

      // reset mid-frame
      load(2);
      clear_log();
      pulse_start();
      repeat (15) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_valid", 64'(mel_valid), 64'd0);
      check("mr_err", 64'(err), 64'd0);
      check("mr_out", 64'({mel_idx, mel_data}), 64'd0);
      check("mr_addr", 64'({spec_addr, rom_addr}), 64'd0);
      rst = 1'b0;
      clear_log();
      repeat (60) @(posedge clk);
      #1;
      check("mr_no_done", 64'(done_cnt), 64'd0);
      check("mr_no_xfer", 64'(got_idx.size()), 64'd0);
      load(0);
      clear_log();
      pulse_start();
      wait_done();
      check_frame(0, "mr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
